mips_ctrl_fsm: RTL
==================

// Module: mips_ctrl_fsm
// PURPOSE
//  Multi-cycle sequencer for the MIPS CPU. Owns the state register the decoder reads.
//  Drives the Avalon-style memory handshake: read/write/byteenable, stalled by waitrequest.
//  Issues one-cycle commit strobes for PC, IR, MDR, register file and hi/lo.
//  Adds a mult/div stall counter and halt-on-jump-to-zero; the combinational decoder
//  keeps all datapath select signals.
// PARAMETERS
//  MULDIV_CYCLES  4  cycles spent in MULDIV for funct 24-27 (legal 1..15)
//  STATE_W        3  width of state output
// PORTS
//  clk              in   1   clock, all state on rising edge
//  reset_n          in   1   asynchronous active-low reset
//  opcode           in   6   IR[31:26], valid from EXEC onward
//  function_code    in   6   IR[5:0]
//  addr_lsb         in   2   ALU effective address [1:0], valid in EXEC/MEM
//  pc_next_zero     in   1   next-PC value == 0, valid in the commit cycle
//  waitrequest      in   1   memory stall; transfer accepted when low
//  state            out  3   FETCH=0 EXEC=1 MEM=2 WB=3 MULDIV=4 HALT=5
//  read, write      out  1   memory strobes
//  byteenable       out  4   lane enables for current transfer
//  ir_wren          out  1   IR capture strobe
//  mdr_wren         out  1   load-data capture strobe
//  pc_wren          out  1   PC update strobe (instruction commit)
//  exec_wb          out  1   reg-file write window for non-memory instrs (gated by decoder)
//  load_wb          out  1   reg-file write strobe for loads
//  hilo_wren        out  1   hi/lo update at end of mult/div
//  active           out  1   high until HALT is entered
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   state=FETCH, active=1, counter=0; all strobes 0; byteenable=0; read/write drop at once.
//  After release, FETCH is entered directly.
//  FETCH: read=1, byteenable=4'b1111.
//   - waitrequest=1: hold, outputs stable.
//   - waitrequest=0: ir_wren=1, next=EXEC.
//  EXEC: one cycle.
//   - load (32-38) or store (40,41,43): next=MEM.
//   - opcode 0 with funct 24-27: load counter=MULDIV_CYCLES-1, next=MULDIV.
//   - otherwise: exec_wb=1, pc_wren=1, next = pc_next_zero ? HALT : FETCH.
//  MEM:
//   - read=1 for loads; write=1 for stores; never both.
//   - byteenable: lw/lwl/lwr = 1111.
//   - byteenable: lb/lbu/sb = 0001<<addr_lsb.
//   - byteenable: lh/lhu/sh = addr_lsb[1] ? 1100 : 0011.
//   - waitrequest=1: hold with strobes, byteenable and lane choice unchanged.
//   - accepted, load: mdr_wren=1, next=WB.
//   - accepted, store: pc_wren=1, next = pc_next_zero ? HALT : FETCH.
//  WB: load_wb=1, pc_wren=1, next = pc_next_zero ? HALT : FETCH.
//  MULDIV: counter decrements each cycle.
//   - at counter==0: hilo_wren=1, pc_wren=1, next=FETCH.
//   - total EXEC->FETCH span = MULDIV_CYCLES+1 clocks.
//  HALT: active=0, no strobes, byteenable=0; absorbing until reset_n.
//  Strobes are registered-state decodes, high exactly one cycle per event.
//  Illegal state encodings recover to FETCH next cycle.
//  Reset asserted mid-MEM with write=1: write deasserts asynchronously; nothing commits.
//  Throughput: ALU instr = 2 cycles, store = 3, load = 4 (zero wait states).
// TESTING
//  1. addu (op0/f33), waitrequest=0: state 0,1,0; pc_wren and exec_wb high in cycle 2 only.
//  2. FETCH with waitrequest high 3 cycles: read=1 for 4 cycles; ir_wren once, in cycle 4.
//  3. lb, addr_lsb=2: byteenable=0100 in MEM; mdr_wren then load_wb; sh, addr_lsb=2: 1100, write=1.
//  4. mult, MULDIV_CYCLES=4: MULDIV held 4 cycles; hilo_wren in the 4th; next FETCH.
//  5. jr with pc_next_zero=1: pc_wren=1, then state=5, active=0, read stays 0 for 10 cycles.
//  6. reset_n low mid-MEM store with waitrequest=1: write=0 immediately; state=0 after release.

Source files
------------

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle control sequencer for the MIPS CPU.
// Owns the architectural state register and the Avalon-style memory handshake.
// Emits one-cycle commit strobes for IR, MDR, PC, the register file and hi/lo.
// Datapath select signals stay in the combinational decoder, which reads 'state'.
module mips_ctrl_fsm #(
  parameter int MULDIV_CYCLES = 4,
  parameter int STATE_W       = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         function_code,
  input  logic [1:0]         addr_lsb,
  input  logic               pc_next_zero,
  input  logic               waitrequest,
  output logic [STATE_W-1:0] state,
  output logic               read,
  output logic               write,
  output logic [3:0]         byteenable,
  output logic               ir_wren,
  output logic               mdr_wren,
  output logic               pc_wren,
  output logic               exec_wb,
  output logic               load_wb,
  output logic               hilo_wren,
  output logic               active
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_EXEC   = 3'd1;
  localparam logic [2:0] S_MEM    = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_MULDIV = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [3:0] r_cnt;
  logic       r_mem_load;
  logic [3:0] r_be;

  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_muldiv;
  logic       w_rd, w_wr, w_ir, w_mdr, w_pc, w_exw, w_ldw, w_hilo, w_act;
  logic [3:0] w_be;

  // Byte-lane mask for a load/store opcode at the given address alignment.
  function automatic logic [3:0] lane_mask(input logic [5:0] op, input logic [1:0] lsb);
    logic [3:0] m;
    case (op)
      6'd32, 6'd36, 6'd40: m = 4'b0001 << lsb;
      6'd33, 6'd37, 6'd41: m = lsb[1] ? 4'b1100 : 4'b0011;
      default:             m = 4'b1111;
    endcase
    return m;
  endfunction

  assign w_is_load   = (opcode >= 6'd32) && (opcode <= 6'd38);
  assign w_is_store  = (opcode == 6'd40) || (opcode == 6'd41) || (opcode == 6'd43);
  assign w_is_muldiv = (opcode == 6'd0) && (function_code >= 6'd24) && (function_code <= 6'd27);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  // Mult/div stall counter and the memory access kind/lanes latched when leaving EXEC,
  // so a stalled transfer keeps exactly the same strobes and lanes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= 4'd0;
      r_mem_load <= 1'b0;
      r_be       <= 4'd0;
    end else if (r_state == S_EXEC) begin
      if (w_is_muldiv) r_cnt <= 4'(MULDIV_CYCLES - 1);
      r_mem_load <= w_is_load;
      r_be       <= lane_mask(opcode, addr_lsb);
    end else if ((r_state == S_MULDIV) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = waitrequest ? S_FETCH : S_EXEC;
      S_EXEC: begin
        if (w_is_load || w_is_store) w_next = S_MEM;
        else if (w_is_muldiv)        w_next = S_MULDIV;
        else                         w_next = pc_next_zero ? S_HALT : S_FETCH;
      end
      S_MEM: begin
        if (waitrequest)     w_next = S_MEM;
        else if (r_mem_load) w_next = S_WB;
        else                 w_next = pc_next_zero ? S_HALT : S_FETCH;
      end
      S_WB:     w_next = pc_next_zero ? S_HALT : S_FETCH;
      S_MULDIV: w_next = (r_cnt == 4'd0) ? S_FETCH : S_MULDIV;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  // Output decode from registered state; everything is forced quiet while reset is held
  // so memory strobes drop the instant reset_n falls.
  always_comb begin
    w_rd = 1'b0; w_wr = 1'b0; w_be = 4'd0; w_ir = 1'b0; w_mdr = 1'b0;
    w_pc = 1'b0; w_exw = 1'b0; w_ldw = 1'b0; w_hilo = 1'b0; w_act = 1'b1;
    case (r_state)
      S_FETCH: begin
        w_rd = 1'b1;
        w_be = 4'b1111;
        w_ir = !waitrequest;
      end
      S_EXEC: begin
        if (!(w_is_load || w_is_store || w_is_muldiv)) begin
          w_exw = 1'b1;
          w_pc  = 1'b1;
        end
      end
      S_MEM: begin
        w_rd  = r_mem_load;
        w_wr  = !r_mem_load;
        w_be  = r_be;
        w_mdr = r_mem_load && !waitrequest;
        w_pc  = !r_mem_load && !waitrequest;
      end
      S_WB: begin
        w_ldw = 1'b1;
        w_pc  = 1'b1;
      end
      S_MULDIV: begin
        w_hilo = (r_cnt == 4'd0);
        w_pc   = (r_cnt == 4'd0);
      end
      S_HALT:  w_act = 1'b0;
      default: w_act = 1'b1;
    endcase
    if (!reset_n) begin
      w_rd = 1'b0; w_wr = 1'b0; w_be = 4'd0; w_ir = 1'b0; w_mdr = 1'b0;
      w_pc = 1'b0; w_exw = 1'b0; w_ldw = 1'b0; w_hilo = 1'b0; w_act = 1'b1;
    end
  end

  assign state      = STATE_W'(r_state);
  assign read       = w_rd;
  assign write      = w_wr;
  assign byteenable = w_be;
  assign ir_wren    = w_ir;
  assign mdr_wren   = w_mdr;
  assign pc_wren    = w_pc;
  assign exec_wb    = w_exw;
  assign load_wb    = w_ldw;
  assign hilo_wren  = w_hilo;
  assign active     = w_act;

endmodule
